// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with a registered head; unused slots are held at zero.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_inst,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            clear,
    output logic            head_valid,
    output logic [XLEN-1:0] head_inst,
    output logic [XLEN-1:0] head_pc,
    output logic [1:0]      count
);

    logic [1:0]      count_q;
    logic [XLEN-1:0] head_inst_q;
    logic [XLEN-1:0] head_pc_q;
    logic [XLEN-1:0] tail_inst_q;
    logic [XLEN-1:0] tail_pc_q;
    logic            do_pop;
    logic            do_push;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    assign head_valid = (count_q != 2'd0);
    assign head_inst  = head_inst_q;
    assign head_pc    = head_pc_q;
    assign count      = count_q;

    // The tail slot is zeroed whenever it is vacated, so shifting it into the
    // head on the last pop leaves the head at zero as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            tail_inst_q <= '0;
            tail_pc_q   <= '0;
        end else if (clear) begin
            count_q     <= 2'd0;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            tail_inst_q <= '0;
            tail_pc_q   <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_inst_q <= push_inst;
                        head_pc_q   <= push_pc;
                    end else begin
                        head_inst_q <= tail_inst_q;
                        head_pc_q   <= tail_pc_q;
                        tail_inst_q <= push_inst;
                        tail_pc_q   <= push_pc;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_inst_q <= push_inst;
                        head_pc_q   <= push_pc;
                    end else begin
                        tail_inst_q <= push_inst;
                        tail_pc_q   <= push_pc;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_inst_q <= tail_inst_q;
                    head_pc_q   <= tail_pc_q;
                    tail_inst_q <= '0;
                    tail_pc_q   <= '0;
                    count_q     <= count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request FSM feeding a 2-entry buffer,
// with branch redirect that flushes the buffer and drops in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [1:0] DEPTH = FIFO_DEPTH[1:0];

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] redir_aligned;
    logic            redir_unused;
    logic [1:0]      count;
    logic            pop;
    logic            push;
    logic [1:0]      occ_after_pop;
    logic [1:0]      occ_after_push;

    assign redir_aligned = {redir_pc[XLEN-1:2], 2'b00};
    assign redir_unused  = ^redir_pc[1:0];

    assign pop            = inst_valid && inst_ready;
    assign push           = (state == BUSY) && imem_ack && !redir_valid;
    assign occ_after_pop  = count - {1'b0, pop};
    assign occ_after_push = occ_after_pop + {1'b0, push};

    // fetch_pc only moves on ack or redirect, so it doubles as the stable request address.
    assign imem_addr = fetch_pc;

    fetch_fifo u_fifo (
        .clk        (CLK),
        .rst_n      (RST),
        .push       (push),
        .push_inst  (imem_rdata),
        .push_pc    (fetch_pc),
        .pop        (pop),
        .clear      (redir_valid),
        .head_valid (inst_valid),
        .head_inst  (inst),
        .head_pc    (inst_pc),
        .count      (count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
            imem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir_valid) begin
                        fetch_pc <= redir_aligned;
                        state    <= BUSY;
                        imem_req <= 1'b1;
                    end else if (occ_after_pop < DEPTH) begin
                        state    <= BUSY;
                        imem_req <= 1'b1;
                    end
                end
                BUSY: begin
                    if (redir_valid && imem_ack) begin
                        fetch_pc <= redir_aligned;
                    end else if (redir_valid) begin
                        target_pc <= redir_aligned;
                        state     <= FLUSH;
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        if (occ_after_push >= DEPTH) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // The aborted request must still complete before the new target is issued.
                    if (redir_valid && imem_ack) begin
                        fetch_pc <= redir_aligned;
                        state    <= BUSY;
                    end else if (redir_valid) begin
                        target_pc <= redir_aligned;
                    end else if (imem_ack) begin
                        fetch_pc <= target_pc;
                        state    <= BUSY;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
